uart_rx_frame: RTL and testbench

Oversampling UART receiver that turns the serial line into parallel bytes for the system controller's command path. It detects the start bit, majority-samples every bit at mid-bit, checks optional parity and the stop bit, and emits one single-cycle `data_valid` pulse per good frame. It sits upstream of the data synchronizer that produces `RX_P_DATA`/`RX_D_VLD` in the RX clock domain.

---
 rtl/uart_rx_frame.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : Oversampling UART receiver. Detects the start bit, takes a
//            3-sample majority vote at mid-bit, checks optional parity and
//            the stop bit, and emits one single-cycle result pulse per frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  busy
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] C_LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] C_ONE = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_armed;
    logic [PRESCALE_W-1:0]   r_edge_cnt;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [PRESCALE_W-1:0]   r_prescale;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_par_fail;
    logic [2:0]              r_samples;
    logic [DATA_WIDTH-1:0]   r_shift;

    logic [DATA_WIDTH-1:0]   r_p_data;
    logic                    r_data_valid;
    logic                    r_par_err;
    logic                    r_stp_err;

    logic [PRESCALE_W-1:0]   w_half;
    logic                    w_start_det;
    logic                    w_bit_end;
    logic                    w_vote;
    logic                    w_last_bit;
    logic                    w_frame_done;

    // Mid-bit sample points and end-of-bit strobe derived from the latched ratio.
    assign w_half       = r_prescale >> 1;
    assign w_start_det  = (r_state == IDLE) && r_armed && !RX_IN;
    assign w_bit_end    = (r_state != IDLE) && (r_edge_cnt == (r_prescale - C_ONE));
    assign w_vote       = (r_samples[0] & r_samples[1]) |
                          (r_samples[0] & r_samples[2]) |
                          (r_samples[1] & r_samples[2]);
    assign w_last_bit   = (r_bit_cnt == C_LAST_BIT);
    assign w_frame_done = (r_state == STOP) && w_bit_end;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; every transition other than start detection happens at end of bit.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_det) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_next_state = w_vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_end && w_last_bit) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Arming, bit timing, majority sampling, shift register and parity tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_armed    <= 1'b0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_prescale <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_fail <= 1'b0;
            r_samples  <= '0;
            r_shift    <= '0;
        end else begin
            // A line held low through reset is not a start bit until it has been seen idle.
            if (RX_IN) begin
                r_armed <= 1'b1;
            end

            if (w_start_det) begin
                // The detection cycle is edge 0 of the start bit.
                r_edge_cnt <= C_ONE;
                r_bit_cnt  <= '0;
                r_prescale <= Prescale;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_par_fail <= 1'b0;
            end else if (r_state != IDLE) begin
                r_edge_cnt <= w_bit_end ? '0 : (r_edge_cnt + C_ONE);

                if (r_edge_cnt == (w_half - C_ONE)) begin
                    r_samples[0] <= RX_IN;
                end
                if (r_edge_cnt == w_half) begin
                    r_samples[1] <= RX_IN;
                end
                if (r_edge_cnt == (w_half + C_ONE)) begin
                    r_samples[2] <= RX_IN;
                end

                if (w_bit_end && (r_state == DATA)) begin
                    r_shift[r_bit_cnt] <= w_vote;
                    r_bit_cnt          <= w_last_bit ? '0 : (r_bit_cnt + 1'b1);
                end

                if (w_bit_end && (r_state == PARITY)) begin
                    if (w_vote != ((^r_shift) ^ r_par_typ)) begin
                        r_par_fail <= 1'b1;
                    end
                end
            end
        end
    end

    // Frame result: one exclusive pulse; a stop error masks a parity error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            if (w_frame_done) begin
                if (!w_vote) begin
                    r_stp_err <= 1'b1;
                end else if (r_par_fail) begin
                    r_par_err <= 1'b1;
                end else begin
                    r_data_valid <= 1'b1;
                    r_p_data     <= r_shift;
                end
            end
        end
    end

    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;
    assign Par_Err    = r_par_err;
    assign Stp_Err    = r_stp_err;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Self-checking bench for uart_rx_frame. The driver pushes the
//            hand-computed result of each frame into a scoreboard queue; a
//            monitor pops and compares whenever a result pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame;

    localparam int K_DV  = 0;
    localparam int K_PAR = 1;
    localparam int K_STP = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       Par_Err;
    logic       Stp_Err;
    logic       busy;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Counts rising edges; at a falling edge it equals the index of the last rising edge.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge CLK) begin
        if (data_valid || Par_Err || Stp_Err) begin
            exp_t e;
            int   k;
            chk("pulse_exclusive", int'(data_valid) + int'(Par_Err) + int'(Stp_Err), 1);
            k = data_valid ? K_DV : (Par_Err ? K_PAR : K_STP);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = q.pop_front();
                chk({e.tag, "_kind"}, k, e.kind);
                chk({e.tag, "_cycle"}, cyc, e.cyc);
                chk({e.tag, "_pdata"}, int'(P_DATA), int'(e.data));
            end
        end
    end

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    // Sends one frame after gap idle cycles; the expected result is supplied by the caller.
    task automatic send_frame(input int gap, input int p, input bit pen, input bit ptyp,
                              input logic [7:0] d, input bit pbit, input bit sbit,
                              input int kind, input logic [7:0] expd, input string tag);
        exp_t e;
        RX_IN = 1'b1;
        repeat (gap) @(negedge CLK);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        e.kind = kind;
        e.data = expd;
        e.cyc  = cyc + (10 + int'(pen)) * p;
        e.tag  = tag;
        q.push_back(e);
        drive_bit(1'b0, p);
        // Configuration changes mid-frame must be ignored.
        Prescale = (p == 8) ? 6'd32 : 6'd8;
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_pdata"}, int'(P_DATA), 0);
        chk({tag, "_dv"}, int'(data_valid), 0);
        chk({tag, "_perr"}, int'(Par_Err), 0);
        chk({tag, "_serr"}, int'(Stp_Err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RST = 1'b0;

        // P=8, no parity, 0xA5 -> valid at +80.
        send_frame(4, 8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, K_DV, 8'hA5, "a5_p8");
        // P=16, even parity, 0x37 has five ones -> parity bit 1 is correct.
        send_frame(3, 16, 1'b1, 1'b0, 8'h37, 1'b1, 1'b1, K_DV, 8'h37, "37_par_ok");
        // Wrong parity bit -> Par_Err, P_DATA holds 0x37.
        send_frame(3, 16, 1'b1, 1'b0, 8'h37, 1'b0, 1'b1, K_PAR, 8'h37, "37_par_bad");
        // Good parity, stop bit 0 -> Stp_Err only.
        send_frame(3, 16, 1'b1, 1'b0, 8'h37, 1'b1, 1'b0, K_STP, 8'h37, "37_stop_bad");
        // Both parity and stop wrong -> Stp_Err only.
        send_frame(3, 16, 1'b1, 1'b0, 8'h37, 1'b0, 1'b0, K_STP, 8'h37, "37_both_bad");
        // Odd parity at P=8, 0x01 has one one -> odd parity bit 0.
        send_frame(3, 8, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, K_DV, 8'h01, "01_odd_ok");

        // Start glitch: low for 2 cycles at P=8, back to IDLE after cycle 7.
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        Prescale = 6'd8;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (5) @(negedge CLK);
        chk("glitch_busy_c7", int'(busy), 1);
        @(negedge CLK);
        chk("glitch_busy_c8", int'(busy), 0);
        repeat (4) @(negedge CLK);

        // Back-to-back 0x00 then 0xFF at P=32, second start right at cycle N*P.
        send_frame(2, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, K_DV, 8'h00, "b2b_00");
        send_frame(0, 32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, K_DV, 8'hFF, "b2b_ff");

        // Reset at cycle 40 of a P=8 frame: no pulse, all outputs cleared.
        RX_IN = 1'b1;
        repeat (4) @(negedge CLK);
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 8);
        chk("midframe_busy", int'(busy), 1);
        RST   = 1'b1;
        RX_IN = 1'b0;
        @(negedge CLK);
        check_idle_outputs("midreset");
        @(negedge CLK);
        RST = 1'b0;
        // Line held low after reset must not be taken as a start bit.
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            chk("disarmed_busy", int'(busy), 0);
        end
        send_frame(1, 8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, K_DV, 8'h5A, "post_reset_5a");

        RX_IN = 1'b1;
        repeat (20) @(negedge CLK);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
